// File: rtl/branch_resolution_unit.sv
// EX-stage branch resolver: carries PC/prediction through IF/ID and ID/EX, computes the actual
// next-PC, and raises flush on a mispredict. Optional perf counters under BRU_PERF_CNT_EN.
module branch_resolution_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_pc_predict,
  input  logic             stall,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             ex_bcond,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  output logic [31:0]      ID_EX_pc,
  output logic [31:0]      pc_correct,
  output logic             prediction_sucess,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pred;
  logic        idex_valid;
  logic [31:0] idex_pc;
  logic [31:0] idex_pred;
  logic [31:0] actual_next;
  logic [31:0] seq_next;

  assign seq_next = idex_pc + 32'd4;

  // jalr outranks jal, which outranks a conditional branch
  always_comb begin
    actual_next = seq_next;
    if (ex_is_jalr) begin
      actual_next = (ex_rs1 + ex_imm) & ~32'h1;
    end else if (ex_is_jal) begin
      actual_next = idex_pc + ex_imm;
    end else if (ex_is_branch && ex_bcond) begin
      actual_next = idex_pc + ex_imm;
    end
  end

  assign ID_EX_pc          = idex_pc;
  assign pc_correct        = idex_valid ? actual_next : seq_next;
  assign prediction_sucess = !idex_valid || (idex_pred == actual_next);
  assign flush             = !prediction_sucess;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_pred  <= '0;
      idex_valid <= 1'b0;
      idex_pc    <= '0;
      idex_pred  <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
      idex_valid <= 1'b0;
    end else if (stall) begin
      // IF/ID holds; a bubble enters EX
      idex_valid <= 1'b0;
    end else begin
      ifid_valid <= if_valid;
      ifid_pc    <= if_pc;
      ifid_pred  <= if_pc_predict;
      idex_valid <= ifid_valid;
      idex_pc    <= ifid_pc;
      idex_pred  <= ifid_pred;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt_r;
  logic [CNT_W-1:0] mispredict_cnt_r;
  logic             resolve_ev;

  assign resolve_ev = idex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr) && !stall;

  // Both counters saturate at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_r     <= '0;
      mispredict_cnt_r <= '0;
    end else begin
      if (resolve_ev && (branch_cnt_r != '1)) begin
        branch_cnt_r <= branch_cnt_r + CNT_W'(1);
      end
      if (flush && (mispredict_cnt_r != '1)) begin
        mispredict_cnt_r <= mispredict_cnt_r + CNT_W'(1);
      end
    end
  end

  assign branch_cnt     = branch_cnt_r;
  assign mispredict_cnt = mispredict_cnt_r;
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed plus random bench for branch_resolution_unit against a slot-based pipeline model.
module tb_branch_resolution_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_predict;
  logic        stall;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        ex_bcond;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic [31:0] ID_EX_pc;
  logic [31:0] pc_correct;
  logic        prediction_sucess;
  logic        flush;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  // Model: slot 0 = decode, slot 1 = execute
  bit          m_v[2];
  logic [31:0] m_pc[2];
  logic [31:0] m_pred[2];
  longint      m_bcnt;
  longint      m_mcnt;
  logic [31:0] before_m;

  branch_resolution_unit #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .if_pc_predict(if_pc_predict), .stall(stall), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_bcond(ex_bcond), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ID_EX_pc(ID_EX_pc), .pc_correct(pc_correct),
    .prediction_sucess(prediction_sucess), .flush(flush), .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_target();
    logic [31:0] t;
    if (ex_is_jalr)                   t = {ex_rs1 + ex_imm} & 32'hFFFF_FFFE;
    else if (ex_is_jal)               t = m_pc[1] + ex_imm;
    else if (ex_is_branch && ex_bcond) t = m_pc[1] + ex_imm;
    else                              t = m_pc[1] + 32'd4;
    return t;
  endfunction

  function automatic bit model_ok();
    return !m_v[1] || (m_pred[1] == model_target());
  endfunction

  function automatic logic [31:0] exp_cnt(input longint c);
`ifdef BRU_PERF_CNT_EN
    return 32'(c);
`else
    return 32'(c * 0);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_pc[i] = '0; m_pred[i] = '0;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  task automatic model_check();
    chk("success", {31'd0, prediction_sucess}, {31'd0, model_ok()});
    chk("flush", {31'd0, flush}, {31'd0, !model_ok()});
    if (m_v[1]) begin
      chk("idex_pc", ID_EX_pc, m_pc[1]);
      chk("pc_correct", pc_correct, model_target());
    end
    chk("branch_cnt", branch_cnt, exp_cnt(m_bcnt));
    chk("mispredict_cnt", mispredict_cnt, exp_cnt(m_mcnt));
  endtask

  // Apply one cycle's inputs; flags given as kind: 0 none, 1 branch, 2 jal, 3 jalr
  task automatic drive(input bit iv, input logic [31:0] ipc, input logic [31:0] ipred,
                       input bit st, input int kind, input bit bc, input logic [31:0] imm,
                       input logic [31:0] rs1);
    if_valid = iv; if_pc = ipc; if_pc_predict = ipred; stall = st;
    ex_is_branch = (kind == 1); ex_is_jal = (kind == 2); ex_is_jalr = (kind == 3);
    ex_bcond = bc; ex_imm = imm; ex_rs1 = rs1;
    #1;
    model_check();
  endtask

  task automatic tick();
    bit fl;
    fl = !model_ok();
    if (m_v[1] && (ex_is_branch || ex_is_jal || ex_is_jalr) && !stall && m_bcnt < 64'hFFFF_FFFF)
      m_bcnt++;
    if (fl && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
    @(posedge clk);
    if (fl) begin
      m_v[0] = 0; m_v[1] = 0;
    end else if (stall) begin
      m_v[1] = 0;
    end else begin
      m_v[1] = m_v[0]; m_pc[1] = m_pc[0]; m_pred[1] = m_pred[0];
      m_v[0] = if_valid; m_pc[0] = if_pc; m_pred[0] = if_pc_predict;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    if_valid = 0; if_pc = '0; if_pc_predict = '0; stall = 0;
    ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_bcond = 0; ex_imm = '0; ex_rs1 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_held_flush", {31'd0, flush}, 32'd0);
    reset = 1'b0;

    // 1: reset values
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_idex_pc", ID_EX_pc, 32'h0);
    chk("rst_pc_correct", pc_correct, 32'h4);
    chk("rst_success", {31'd0, prediction_sucess}, 32'd1);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    tick();

    // 2: sequential instruction, correct prediction
    drive(1, 32'h100, 32'h104, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_idex_pc", ID_EX_pc, 32'h100);
    chk("t2_pc_correct", pc_correct, 32'h104);
    chk("t2_success", {31'd0, prediction_sucess}, 32'd1);
    tick();

    // 3: taken branch mispredicted, younger fetch squashed
    drive(1, 32'h200, 32'h204, 0, 0, 0, 0, 0); tick();
    drive(1, 32'h204, 32'h208, 0, 0, 0, 0, 0); tick();
    drive(1, 32'h208, 32'h20c, 0, 1, 1, 32'h40, 0);
    chk("t3_pc_correct", pc_correct, 32'h240);
    chk("t3_flush", {31'd0, flush}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'h40, 0);
    chk("t3_ex_invalid", {31'd0, prediction_sucess}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'h40, 0);
    chk("t3_id_invalid", {31'd0, prediction_sucess}, 32'd1);
    tick();

    // 4: jalr target has bit 0 cleared
    drive(1, 32'h300, 32'h1004, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 3, 0, 32'h4, 32'h1001);
    chk("t4_pc_correct", pc_correct, 32'h1004);
    chk("t4_success", {31'd0, prediction_sucess}, 32'd1);
    tick();

    // 5: two-cycle stall holds 0x400 in decode
    drive(1, 32'h400, 32'h404, 0, 0, 0, 0, 0); tick();
    drive(1, 32'h999, 32'h0, 1, 1, 1, 32'h40, 0); tick();
    drive(1, 32'h999, 32'h0, 1, 1, 1, 32'h40, 0);
    chk("t5_bubble1", {31'd0, prediction_sucess}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'h40, 0);
    chk("t5_bubble2", {31'd0, prediction_sucess}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_idex_pc", ID_EX_pc, 32'h400);
    chk("t5_pc_correct", pc_correct, 32'h404);
    tick();

    // Asynchronous reset with a mispredicted instruction in EX
    drive(1, 32'h700, 32'h800, 0, 0, 0, 0, 0); tick();
    drive(1, 32'h704, 32'h708, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_flush_pre", {31'd0, flush}, 32'd1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_idex_pc", ID_EX_pc, 32'h0);
    chk("mid_rst_pc_correct", pc_correct, 32'h4);
    chk("mid_rst_flush", {31'd0, flush}, 32'd0);
    chk("mid_rst_mcnt", mispredict_cnt, 32'd0);
    reset = 1'b0;
    tick();

    // 6: mispredict during stall, then a second one on the refetched path
    drive(1, 32'h500, 32'h504, 0, 0, 0, 0, 0); tick();
    drive(1, 32'h504, 32'h508, 0, 0, 0, 0, 0); tick();
    drive(1, 32'h508, 32'h50c, 1, 2, 0, 32'h100, 0);
    chk("t6_flush1", {31'd0, flush}, 32'd1);
    chk("t6_pc_correct1", pc_correct, 32'h600);
    tick();
    drive(1, 32'h600, 32'h604, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 1, 32'hFFFF_FF80, 0);
    chk("t6_flush2", {31'd0, flush}, 32'd1);
    chk("t6_pc_correct2", pc_correct, 32'h580);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef BRU_PERF_CNT_EN
    chk("t6_mcnt", mispredict_cnt, 32'd2);
`else
    chk("t6_mcnt", mispredict_cnt, 32'd0);
`endif
    tick();

    // Random traffic, including conflicting control-flow flags
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      before_m = {r[31:12], 12'h0};
      if_valid = r[0]; if_pc = before_m; stall = ($urandom_range(0, 4) == 0);
      if_pc_predict = r[1] ? before_m + 32'd4 : {$urandom_range(0, 1023), 2'b00};
      ex_is_branch = ($urandom_range(0, 3) == 0);
      ex_is_jal    = ($urandom_range(0, 5) == 0);
      ex_is_jalr   = ($urandom_range(0, 5) == 0);
      ex_bcond     = r[2];
      r = $urandom;
      ex_imm = {{22{r[9]}}, r[9:2], 2'b00};
      ex_rs1 = $urandom;
      #1;
      model_check();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
